// File: rtl/cam_pkg.sv
// Shared types and geometry helpers for the camera frame reader.
package cam_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_READ, ST_RELEASE} cam_state_e;

  localparam int R_W    = 5;
  localparam int G_W    = 6;
  localparam int B_W    = 5;
  localparam int PIX_W  = R_W + G_W + B_W;
  localparam int WORD_W = 2 * PIX_W;
  localparam int X_W    = 9;
  localparam int Y_W    = 8;

  // Two RGB565 pixels are packed per RAM word.
  function automatic int frame_words(input int w, input int h);
    return w * h / 2;
  endfunction
endpackage

// File: rtl/cam_word_fifo.sv
// 2-deep word FIFO between the RAM read port and the pixel unpacker.
module cam_word_fifo
  import cam_pkg::*;
(
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);
  logic [WORD_W-1:0] mem [2];
  logic wptr, rptr;
  logic do_push, do_pop;

  assign do_pop  = pop && !empty;
  // A full FIFO may accept a push in the same cycle as a pop: the slot being
  // overwritten is the head, which is read combinationally before the edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
endmodule

// File: rtl/camera_frame_reader.sv
// Reads a captured frame out of the capture RAM and streams it as RGB565
// pixels with x/y position and frame markers.
module camera_frame_reader
  import cam_pkg::*;
#(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int AW      = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [AW-1:0]     ram_raddr,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);
  localparam int             WORDS     = frame_words(FRAME_W, FRAME_H);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(WORDS - 1);
  localparam logic [X_W-1:0] X_LAST    = X_W'(FRAME_W - 1);
  localparam logic [Y_W-1:0] Y_LAST    = Y_W'(FRAME_H - 1);

  cam_state_e        state;
  logic              in_flight, fetch_done, half;
  logic              issue, beat, pop;
  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_count;
  logic [WORD_W-1:0] head;

  // At most two words are ever owned (in flight + buffered), so no word can
  // return into a full FIFO under back-pressure.
  assign issue = (state == ST_READ) && !fetch_done && !fifo_full &&
                 ({1'b0, fifo_count} + {2'b0, in_flight} < 3'd2);
  assign beat  = pix_valid && pix_ready;
  assign pop   = beat && half;

  cam_word_fifo u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (in_flight),
    .pop     (pop),
    .wdata   (ram_rdata),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign busy      = (state != ST_IDLE);
  assign pix_valid = !fifo_empty;
  assign pix_data  = half ? head[WORD_W-1:PIX_W] : head[PIX_W-1:0];
  assign pix_sof   = pix_valid && (pix_x == '0) && (pix_y == '0);
  assign pix_eol   = pix_valid && (pix_x == X_LAST);
  assign pix_eof   = pix_eol && (pix_y == Y_LAST);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      frame_valid <= 1'b0;
      done        <= 1'b0;
      in_flight   <= 1'b0;
      fetch_done  <= 1'b0;
      half        <= 1'b0;
      ram_raddr   <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
    end else begin
      done      <= 1'b0;
      in_flight <= issue;
      // Address saturates on the last word so it reads back as the final one fetched.
      if (issue) begin
        if (ram_raddr == LAST_ADDR) fetch_done <= 1'b1;
        else                        ram_raddr  <= ram_raddr + AW'(1);
      end
      if (beat) begin
        half <= ~half;
        if (pix_x == X_LAST) begin
          pix_x <= '0;
          pix_y <= (pix_y == Y_LAST) ? '0 : pix_y + Y_W'(1);
        end else begin
          pix_x <= pix_x + X_W'(1);
        end
      end
      case (state)
        ST_IDLE: if (start) begin
          state       <= ST_REQ;
          frame_valid <= 1'b1;
          ram_raddr   <= '0;
          fetch_done  <= 1'b0;
          half        <= 1'b0;
          pix_x       <= '0;
          pix_y       <= '0;
        end
        ST_REQ:  if (frame_ready) state <= ST_READ;
        ST_READ: if (beat && pix_eof) begin
          state       <= ST_RELEASE;
          frame_valid <= 1'b0;
        end
        ST_RELEASE: if (!frame_ready) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
